// File: rtl/fifo_drain_pkg.sv
// rtl/fifo_drain_pkg.sv - shared state encoding and sizing helper for the FIFO drainer
package fifo_drain_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_ACK   = 3'd2,
        ST_WAIT  = 3'd3,
        ST_END   = 3'd4,
        ST_ERR   = 3'd5
    } drain_state_t;

    // Width of a counter that must reach TIMEOUT; never narrower than one bit.
    function automatic int tmo_cnt_w(input int timeout);
        return (timeout < 2) ? 1 : $clog2(timeout + 1);
    endfunction

endpackage

// File: rtl/fifo_drain_prefetch.sv
// rtl/fifo_drain_prefetch.sv - one-word prefetch slot in front of the output register
module fifo_drain_prefetch #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic              take,
    input  logic              flush,
    input  logic [DATA_W-1:0] rd_data,
    output logic [DATA_W-1:0] slot_data,
    output logic              slot_valid,
    output logic              pending
);

    // A read already issued to the FIFO always lands, even while the block is frozen:
    // the FIFO has committed the word and would otherwise lose it.
    always_ff @(posedge clk) begin
        if (reset) begin
            slot_data  <= '0;
            slot_valid <= 1'b0;
            pending    <= 1'b0;
        end else if (flush) begin
            slot_valid <= 1'b0;
            pending    <= 1'b0;
        end else begin
            pending <= load;
            if (pending) begin
                slot_valid <= 1'b1;
                slot_data  <= rd_data;
            end else if (take) begin
                slot_valid <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/fifo_drain_burst.sv
// rtl/fifo_drain_burst.sv - FIFO-to-sink word drainer with burst/stream modes and timeout
module fifo_drain_burst
    import fifo_drain_pkg::*;
#(
    parameter int DATA_W  = 8,
    parameter int CNT_W   = 8,
    parameter int TIMEOUT = 1023
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic              go,
    input  logic [CNT_W-1:0]  burst_len,
    input  logic              go_stop,
    input  logic              clear_err,
    input  logic              fifo_empty,
    input  logic              fifo_busy,
    input  logic [DATA_W-1:0] fifo_data,
    output logic              fifo_re,
    output logic [DATA_W-1:0] out_data,
    output logic              out_start,
    input  logic              out_finish,
    output logic              busy,
    output logic              done,
    output logic [CNT_W-1:0]  sent_count,
    output logic              timeout_err
);

    localparam int TW = tmo_cnt_w(TIMEOUT);
    localparam logic [TW-1:0] TMO_LAST = TW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    drain_state_t      state, state_nxt;
    logic [CNT_W-1:0]  len_q;
    logic [CNT_W-1:0]  rd_count;
    logic [CNT_W-1:0]  sent_inc;
    logic [TW-1:0]     tmo_cnt;
    logic              stop_q;
    logic              stop_now;
    logic              run;
    logic              under_limit;
    logic              last_word;
    logic              tmo_hit;
    logic              take;
    logic              flush;
    logic [DATA_W-1:0] slot_data;
    logic              slot_valid;
    logic              pending;

    fifo_drain_prefetch #(
        .DATA_W(DATA_W)
    ) u_prefetch (
        .clk       (clk),
        .reset     (reset),
        .load      (fifo_re),
        .take      (take),
        .flush     (flush),
        .rd_data   (fifo_data),
        .slot_data (slot_data),
        .slot_valid(slot_valid),
        .pending   (pending)
    );

    assign run         = (state == ST_FETCH) || (state == ST_ACK) || (state == ST_WAIT);
    assign stop_now    = stop_q || go_stop;
    assign under_limit = (len_q == '0) || (rd_count < len_q);
    assign sent_inc    = sent_count + CNT_W'(1);
    assign last_word   = (len_q != '0) && (sent_inc == len_q);
    assign tmo_hit     = (TIMEOUT != 0) && (tmo_cnt == TMO_LAST);
    assign busy        = (state != ST_IDLE);
    assign done        = enable && (state == ST_END);

    // Reads stop once the burst's words are all fetched or a stop is requested,
    // so nothing is pulled from the FIFO that the run will not send.
    assign fifo_re = enable && run && !stop_now && under_limit &&
                     !fifo_empty && !fifo_busy && !slot_valid && !pending;

    always_comb begin
        state_nxt = state;
        take      = 1'b0;
        flush     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (go) state_nxt = ST_FETCH;
            end
            ST_FETCH: begin
                if (stop_now) begin
                    state_nxt = ST_END;
                end else if (slot_valid && out_finish) begin
                    state_nxt = ST_ACK;
                    take      = 1'b1;
                end
            end
            ST_ACK: begin
                if (!out_finish)  state_nxt = ST_WAIT;
                else if (tmo_hit) state_nxt = ST_ERR;
            end
            ST_WAIT: begin
                if (out_finish)   state_nxt = (last_word || stop_now) ? ST_END : ST_FETCH;
                else if (tmo_hit) state_nxt = ST_ERR;
            end
            ST_END: begin
                state_nxt = ST_IDLE;
                flush     = 1'b1;
            end
            ST_ERR: begin
                if (clear_err) begin
                    state_nxt = ST_IDLE;
                    flush     = 1'b1;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
        if (!enable) begin
            state_nxt = state;
            take      = 1'b0;
            flush     = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ST_IDLE;
            len_q       <= '0;
            rd_count    <= '0;
            sent_count  <= '0;
            tmo_cnt     <= '0;
            stop_q      <= 1'b0;
            out_data    <= '0;
            out_start   <= 1'b0;
            timeout_err <= 1'b0;
        end else if (enable) begin
            state <= state_nxt;
            if (state == ST_IDLE && go) begin
                len_q      <= burst_len;
                rd_count   <= '0;
                sent_count <= '0;
                stop_q     <= 1'b0;
            end
            if (run && go_stop) stop_q <= 1'b1;
            if (fifo_re) rd_count <= rd_count + CNT_W'(1);
            if (take) begin
                out_data  <= slot_data;
                out_start <= 1'b1;
            end
            if (state == ST_ACK && state_nxt != ST_ACK) out_start <= 1'b0;
            if (state == ST_WAIT && out_finish) sent_count <= sent_inc;
            // The watchdog only measures how long the sink sits on one handshake edge.
            if (state_nxt != state || !(state == ST_ACK || state == ST_WAIT))
                tmo_cnt <= '0;
            else
                tmo_cnt <= tmo_cnt + TW'(1);
            if (state != ST_ERR && state_nxt == ST_ERR)
                timeout_err <= 1'b1;
            else if (state == ST_ERR && clear_err)
                timeout_err <= 1'b0;
        end
    end

endmodule

// File: tb/tb_fifo_drain_burst.sv
// tb/tb_fifo_drain_burst.sv - scoreboard bench for fifo_drain_burst
module tb_fifo_drain_burst;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       enable = 1'b1;
    logic       go = 1'b0;
    logic [7:0] burst_len = 8'd0;
    logic       go_stop = 1'b0;
    logic       clear_err = 1'b0;
    logic       fifo_empty = 1'b1;
    logic       fifo_busy = 1'b0;
    logic [7:0] fifo_data = 8'd0;
    logic       fifo_re;
    logic [7:0] out_data;
    logic       out_start;
    logic       out_finish = 1'b1;
    logic       busy;
    logic       done;
    logic [7:0] sent_count;
    logic       timeout_err;

    logic [7:0] fifo_q[$];
    logic [7:0] exp_q[$];
    logic [7:0] exp_cnt_q[$];
    logic [7:0] last_exp = 8'd0;
    int checks = 0;
    int errors = 0;
    int n_starts = 0;
    int n_done = 0;
    int max_gap = 0;
    int reads_in_ack = 0;
    int busy_pct = 0;
    int sink_dly_min = 0;
    int sink_dly_max = 0;
    int sink_tail_max = 0;
    bit sink_dead = 0;
    bit sink_rst = 0;

    fifo_drain_burst #(.DATA_W(8), .CNT_W(8), .TIMEOUT(15)) dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .go         (go),
        .burst_len  (burst_len),
        .go_stop    (go_stop),
        .clear_err  (clear_err),
        .fifo_empty (fifo_empty),
        .fifo_busy  (fifo_busy),
        .fifo_data  (fifo_data),
        .fifo_re    (fifo_re),
        .out_data   (out_data),
        .out_start  (out_start),
        .out_finish (out_finish),
        .busy       (busy),
        .done       (done),
        .sent_count (sent_count),
        .timeout_err(timeout_err)
    );

    initial forever #5 clk = ~clk;

    initial begin
        #3_000_000;
        $display("FAIL watchdog: got no end of test expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_sink(input int dmin, input int dmax, input int tail);
        sink_dly_min  = dmin;
        sink_dly_max  = dmax;
        sink_tail_max = tail;
    endtask

    // Words queued for the DUT are also the words the sink must receive, in order.
    task automatic load(input int n, input bit expect_it);
        logic [7:0] w;
        for (int i = 0; i < n; i++) begin
            w = 8'($urandom);
            fifo_q.push_back(w);
            if (expect_it) exp_q.push_back(w);
        end
    endtask

    task automatic start_burst(input int len);
        burst_len = 8'(len);
        go = 1'b1;
        step();
        go = 1'b0;
    endtask

    task automatic wait_starts(input int n, input string name);
        int k = 0;
        while (n_starts < n && k < 300) begin
            step();
            k++;
        end
        check(name, 32'(n_starts >= n), 32'd1);
    endtask

    task automatic wait_done(input int n, input string name);
        int k = 0;
        while (n_done < n && k < 400) begin
            step();
            k++;
        end
        check(name, 32'(n_done >= n), 32'd1);
    endtask

    // FIFO with one-cycle read latency; inputs change just after the clock edge.
    initial begin : fifo_model
        logic re_s;
        forever begin
            @(negedge clk);
            re_s = fifo_re;
            @(posedge clk);
            #1;
            if (re_s && fifo_q.size() > 0) fifo_data = fifo_q.pop_front();
            fifo_empty = (fifo_q.size() == 0);
            fifo_busy  = ($urandom_range(99, 0) < busy_pct);
        end
    end

    // Sink: drops finish after a delay, holds it low until start falls, then idles again.
    initial begin : sink_model
        int phase;
        int cnt;
        logic st_s;
        phase = 0;
        cnt = 0;
        forever begin
            @(negedge clk);
            st_s = out_start;
            @(posedge clk);
            #1;
            if (sink_rst) begin
                phase = 0;
                out_finish = 1'b1;
            end else begin
                if (phase == 0 && st_s && !sink_dead) begin
                    cnt = $urandom_range(sink_dly_max, sink_dly_min);
                    phase = 1;
                end else if (phase == 2 && !st_s) begin
                    cnt = $urandom_range(sink_tail_max, 0);
                    phase = 3;
                end
                if (phase == 1) begin
                    if (cnt == 0) begin out_finish = 1'b0; phase = 2; end
                    else cnt--;
                end else if (phase == 3) begin
                    if (cnt == 0) begin out_finish = 1'b1; phase = 0; end
                    else cnt--;
                end
            end
        end
    end

    initial begin : monitor
        logic prev_start;
        logic prev_fin;
        logic counting;
        logic [7:0] e;
        int gap;
        prev_start = 1'b0;
        prev_fin = 1'b1;
        counting = 1'b0;
        gap = 0;
        forever begin
            @(negedge clk);
            if (out_start && !prev_start) begin
                n_starts++;
                if (counting && gap > max_gap) max_gap = gap;
                counting = 1'b0;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL word_unexpected: got %02h expected none", out_data);
                end else begin
                    e = exp_q.pop_front();
                    last_exp = e;
                    check("word", 32'(out_data), 32'(e));
                end
            end else if (busy && out_finish && !prev_fin && !out_start) begin
                counting = 1'b1;
                gap = 0;
            end else if (counting && !out_start) begin
                gap++;
            end
            if (fifo_re && out_start) reads_in_ack++;
            if (done) begin
                n_done++;
                counting = 1'b0;
                if (exp_cnt_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL done_unexpected: got done expected none");
                end else begin
                    check("done_sent_count", 32'(sent_count), 32'(exp_cnt_q.pop_front()));
                end
            end
            prev_start = out_start;
            prev_fin = out_finish;
        end
    end

    initial begin : stimulus
        int base;
        int k;
        int len;
        bit seen;

        repeat (3) step();
        @(negedge clk);
        check("reset_outputs", 32'({fifo_re, out_start, busy, done, timeout_err, sent_count, out_data}), 32'd0);
        step();
        reset = 1'b0;

        // Burst of three fixed words, sink answers 4 cycles after start.
        set_sink(4, 4, 0);
        busy_pct = 0;
        fifo_q.push_back(8'hA5); exp_q.push_back(8'hA5);
        fifo_q.push_back(8'h3C); exp_q.push_back(8'h3C);
        fifo_q.push_back(8'hFF); exp_q.push_back(8'hFF);
        exp_cnt_q.push_back(8'd3);
        base = n_done;
        start_burst(3);
        wait_done(base + 1, "t1_done");
        @(negedge clk);
        check("t1_busy_low", 32'(busy), 32'd0);
        repeat (5) step();
        check("t1_one_done", 32'(n_done - base), 32'd1);
        check("t1_sent_count", 32'(sent_count), 32'd3);

        // Prefetch with a full FIFO and an instant sink.
        set_sink(0, 0, 0);
        load(8, 1'b1);
        exp_cnt_q.push_back(8'd8);
        max_gap = 0;
        reads_in_ack = 0;
        base = n_done;
        step();
        start_burst(8);
        wait_done(base + 1, "t2_done");
        check("t2_read_during_ack", 32'(reads_in_ack > 0), 32'd1);
        check("t2_max_gap_le1", 32'(max_gap <= 1), 32'd1);

        // FIFO runs dry after one of four words, then refills.
        set_sink(0, 3, 2);
        busy_pct = 20;
        load(1, 1'b1);
        exp_cnt_q.push_back(8'd4);
        base = n_done;
        step();
        start_burst(4);
        wait_starts(n_starts + 1, "t3_first_word");
        repeat (14) step();
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (fifo_re) seen = 1'b1;
        end
        check("t3_no_read_when_empty", 32'(seen), 32'd0);
        check("t3_busy_hold", 32'(busy), 32'd1);
        check("t3_sent_one", 32'(sent_count), 32'd1);
        step();
        load(2, 1'b1);
        repeat (40) step();
        @(negedge clk);
        check("t3_sent_three", 32'(sent_count), 32'd3);
        check("t3_busy_still", 32'(busy), 32'd1);
        step();
        load(1, 1'b1);
        wait_done(base + 1, "t3_done");

        // Sink never responds: timeout after 15 cycles in ACK, then cleared.
        busy_pct = 0;
        sink_dead = 1'b1;
        load(1, 1'b1);
        base = n_done;
        step();
        start_burst(1);
        k = 0;
        while (k < 30) begin
            @(negedge clk);
            if (out_start) break;
            k++;
        end
        check("t4_start_seen", 32'(out_start), 32'd1);
        k = 0;
        while (k < 40) begin
            @(negedge clk);
            k++;
            if (timeout_err) break;
        end
        check("t4_timeout_latency", 32'(k), 32'd15);
        check("t4_err_outputs", 32'({out_start, busy, timeout_err}), 32'b011);
        step();
        clear_err = 1'b1;
        step();
        clear_err = 1'b0;
        @(negedge clk);
        check("t4_cleared", 32'({timeout_err, busy}), 32'd0);
        repeat (3) step();
        check("t4_no_done", 32'(n_done - base), 32'd0);
        sink_dead = 1'b0;

        // Stream mode stopped while word 5 is in flight.
        set_sink(1, 3, 1);
        busy_pct = 10;
        load(10, 1'b0);
        for (int i = 0; i < 5; i++) exp_q.push_back(fifo_q[i]);
        exp_cnt_q.push_back(8'd5);
        base = n_done;
        k = n_starts;
        step();
        start_burst(0);
        wait_starts(k + 5, "t5_five_words");
        go_stop = 1'b1;
        step();
        go_stop = 1'b0;
        wait_done(base + 1, "t5_done");
        check("t5_no_extra_words", 32'(exp_q.size()), 32'd0);
        repeat (3) step();
        exp_q.push_back(fifo_q[0]);
        exp_cnt_q.push_back(8'd1);
        start_burst(1);
        wait_done(base + 2, "t5_after_stop_done");
        fifo_q.delete();

        // Reset while the second word is in ACK.
        set_sink(3, 3, 0);
        busy_pct = 0;
        repeat (3) step();
        load(3, 1'b1);
        k = n_starts;
        step();
        start_burst(3);
        wait_starts(k + 2, "t6_second_word");
        reset = 1'b1;
        sink_rst = 1'b1;
        step();
        reset = 1'b0;
        sink_rst = 1'b0;
        @(negedge clk);
        check("t6_reset_mid_ack", 32'({out_start, busy, sent_count}), 32'd0);
        exp_q.delete();
        fifo_q.delete();
        repeat (4) step();

        // Freeze for ten cycles in the middle of a burst.
        set_sink(1, 3, 1);
        load(5, 1'b1);
        exp_cnt_q.push_back(8'd5);
        base = n_done;
        k = n_starts;
        step();
        start_burst(5);
        wait_starts(k + 2, "t7_second_word");
        enable = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("t7_frozen_strobes", 32'({fifo_re, done}), 32'd0);
            check("t7_frozen_data", 32'(out_data), 32'(last_exp));
            step();
        end
        enable = 1'b1;
        wait_done(base + 1, "t7_done");

        // Random bursts with a busy FIFO and a slow sink.
        set_sink(0, 4, 2);
        busy_pct = 30;
        for (int r = 0; r < 4; r++) begin
            len = $urandom_range(6, 1);
            load(len, 1'b1);
            exp_cnt_q.push_back(8'(len));
            base = n_done;
            step();
            start_burst(len);
            wait_done(base + 1, "rand_done");
            repeat ($urandom_range(3, 1)) step();
        end

        check("all_words_seen", 32'(exp_q.size()), 32'd0);
        check("all_dones_seen", 32'(exp_cnt_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
